// File: rtl/uartprobe_axi_pkg.sv
// Shared definitions for the UART probe AXI arbiter: FSM encoding, AXI response
// codes and the fixed single-byte transfer attributes.
package uartprobe_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } axi_state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam logic [2:0] AXI_SIZE_BYTE  = 3'b000;
  localparam logic       AXI_WSTRB_BYTE = 1'b1;

  localparam int unsigned TIMEOUT_W = 16;

  // On a tie the requester that did not win last time is chosen.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/uartprobe_rr_arb.sv
// Two-way round-robin grant; last_grant only advances when the grant is taken.
module uartprobe_rr_arb
  import uartprobe_axi_pkg::*;
(
  input  logic       clk,
  input  logic       aresetn,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;

  assign gnt_valid_o = |req_i;
  assign gnt_id_o    = rr_pick(req_i, last_q);

  always_comb begin
    last_d = last_q;
    if (update_i) last_d = gnt_id_o;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/uartprobe_axi_arb.sv
// Shares the probe's byte-wide AXI master port between two requesters, one
// single-beat transaction at a time, with a response timeout.
module uartprobe_axi_arb
  import uartprobe_axi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned AXI_ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,

  input  logic                  s0_req_valid,
  output logic                  s0_req_ready,
  input  logic                  s0_req_write,
  input  logic [AXI_ADDR_W-1:0] s0_req_addr,
  input  logic [7:0]            s0_req_wdata,
  output logic                  s0_rsp_valid,
  output logic [7:0]            s0_rsp_rdata,
  output logic [1:0]            s0_rsp_resp,

  input  logic                  s1_req_valid,
  output logic                  s1_req_ready,
  input  logic                  s1_req_write,
  input  logic [AXI_ADDR_W-1:0] s1_req_addr,
  input  logic [7:0]            s1_req_wdata,
  output logic                  s1_rsp_valid,
  output logic [7:0]            s1_rsp_rdata,
  output logic [1:0]            s1_rsp_resp,

  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arsize,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [7:0]            m_axi_wdata,
  output logic                  m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic                  m_axi_rvalid,
  input  logic [7:0]            m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  output logic                  m_axi_rready,
  input  logic                  m_axi_bvalid,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_bready
);

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_EN ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

  axi_state_e            state_q, state_d;
  logic                  gnt_id_q, gnt_id_d;
  logic                  write_q, write_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  arvalid_q, arvalid_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;

  logic gnt_valid, gnt_id, accept;
  logic aw_done, w_done, ar_done, timeout_hit;

  uartprobe_rr_arb u_rr_arb (
    .clk         (clk),
    .aresetn     (aresetn),
    .req_i       ({s1_req_valid, s0_req_valid}),
    .update_i    (accept),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Ready is gated by reset so nothing looks accepted while the port is held in reset.
  assign accept       = aresetn && (state_q == ST_IDLE) && gnt_valid;
  assign s0_req_ready = accept && !gnt_id;
  assign s1_req_ready = accept &&  gnt_id;

  // A channel counts as done once its valid has dropped or is being accepted now.
  assign aw_done     = !awvalid_q || m_axi_awready;
  assign w_done      = !wvalid_q  || m_axi_wready;
  assign ar_done     = arvalid_q  && m_axi_arready;
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gnt_id_d  = gnt_id;
          write_d   = gnt_id ? s1_req_write : s0_req_write;
          addr_d    = gnt_id ? s1_req_addr  : s0_req_addr;
          wdata_d   = gnt_id ? s1_req_wdata : s0_req_wdata;
          arvalid_d = !write_d;
          awvalid_d = write_d;
          wvalid_d  = write_d;
          cnt_d     = '0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          arvalid_d = 1'b0;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = RESP_TIMEOUT;
          state_d   = ST_DONE;
        end else if (write_q) begin
          awvalid_d = awvalid_q && !m_axi_awready;
          wvalid_d  = wvalid_q  && !m_axi_wready;
          if (aw_done && w_done) state_d = ST_RESP;
        end else if (ar_done) begin
          arvalid_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 1'b1;
        // A matching response takes priority over a timeout in the same cycle.
        if (!write_q && m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = ST_DONE;
        end else if (write_q && m_axi_bvalid) begin
          rdata_d = '0;
          resp_d  = m_axi_bresp;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          resp_d  = RESP_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      gnt_id_q  <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s0_rsp_valid = (state_q == ST_DONE) && !gnt_id_q;
  assign s1_rsp_valid = (state_q == ST_DONE) &&  gnt_id_q;
  assign s0_rsp_rdata = rdata_q;
  assign s1_rsp_rdata = rdata_q;
  assign s0_rsp_resp  = resp_q;
  assign s1_rsp_resp  = resp_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_arsize  = AXI_SIZE_BYTE;
  assign m_axi_awsize  = AXI_SIZE_BYTE;
  assign m_axi_wstrb   = AXI_WSTRB_BYTE;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_rready  = 1'b1;
  assign m_axi_bready  = 1'b1;

endmodule
